// File: rtl/display_scan_ctrl_if.sv
// Handshake and display bus for display_scan_ctrl: load request in, busy/ovf status
// and the multiplexed digit_code/an drive out.
interface display_scan_ctrl_if;
    logic [13:0] value;
    logic        load;
    logic        blank_lz;
    logic        busy;
    logic        ovf;
    logic [3:0]  digit_code;
    logic [3:0]  an;

    modport master (output value, load, blank_lz, input busy, ovf, digit_code, an);
    modport slave  (input value, load, blank_lz, output busy, ovf, digit_code, an);
endinterface

// File: rtl/display_scan_ctrl.sv
// 4-digit multiplexed display controller: saturating binary->BCD double-dabble
// conversion (one bit per clock), leading-zero blanking and a prescaled digit scan.
module display_scan_ctrl #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    display_scan_ctrl_if.slave   bus
);
    localparam int PW = $clog2(REFRESH_DIV);

    typedef enum logic {IDLE, CONV} state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic [13:0]     r_bin;
    logic [15:0]     r_bcd;
    logic            r_ovf_cap;
    logic            r_busy;
    logic            r_ovf;
    logic [3:0][3:0] r_dig;
    logic [PW-1:0]   r_pre;
    logic [1:0]      r_scan;

    logic [15:0]     w_adj;
    logic [15:0]     w_shift;
    logic [3:0]      w_blank;
    logic [3:0]      w_code;
    logic [3:0]      w_an;

    // Add-3 correction on every nibble >= 5, then shift in the next binary MSB.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
        w_shift = {w_adj[14:0], r_bin[13]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_bin     <= 14'd0;
            r_bcd     <= 16'd0;
            r_ovf_cap <= 1'b0;
            r_busy    <= 1'b0;
            r_ovf     <= 1'b0;
            r_dig     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.load) begin
                        // Saturate at 9999 so an overflow naturally displays 9999.
                        r_bin     <= (bus.value > 14'd9999) ? 14'd9999 : bus.value;
                        r_ovf_cap <= (bus.value > 14'd9999);
                        r_bcd     <= 16'd0;
                        r_cnt     <= 4'd0;
                        r_busy    <= 1'b1;
                        r_state   <= CONV;
                    end
                end
                CONV: begin
                    r_bcd <= w_shift;
                    r_bin <= {r_bin[12:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd13) begin
                        r_dig   <= w_shift;
                        r_ovf   <= r_ovf_cap;
                        r_busy  <= 1'b0;
                        r_cnt   <= 4'd0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre  <= '0;
            r_scan <= 2'd0;
        end else if (r_pre == PW'(REFRESH_DIV - 1)) begin
            r_pre  <= '0;
            r_scan <= r_scan + 2'd1;
        end else begin
            r_pre  <= r_pre + 1'b1;
        end
    end

    // A digit blanks only when it and every more-significant digit are zero.
    always_comb begin
        w_blank[3] = bus.blank_lz && (r_dig[3] == 4'd0);
        w_blank[2] = w_blank[3] && (r_dig[2] == 4'd0);
        w_blank[1] = w_blank[2] && (r_dig[1] == 4'd0);
        w_blank[0] = 1'b0;
        w_code     = w_blank[r_scan] ? 4'hF : r_dig[r_scan];
        w_an       = ~(4'b0001 << r_scan);
    end

    assign bus.busy       = r_busy;
    assign bus.ovf        = r_ovf;
    assign bus.digit_code = w_code;
    assign bus.an         = w_an;
endmodule
